// File: rtl/qsys_button_pkg.sv
// ---------------------------------------------------------------------------
// qsys_button_pkg
// Shared definitions for the push-button event controller: event type codes,
// register map, register bit positions, per-button FSM states and the helper
// functions that pick one pending event out of a button's pending flags.
// ---------------------------------------------------------------------------
package qsys_button_pkg;

  // Event type codes as stored in the FIFO and shown in EVENT[9:8]
  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_LONG    = 2'b11;

  // Register addresses
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_EVENT   = 2'd1;
  localparam logic [1:0] REG_IRQMASK = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  // STATUS / EVENT / CONTROL bit positions
  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_OVF_BIT   = 8;
  localparam int STATUS_LEVEL_LSB = 16;
  localparam int EVENT_VALID_BIT  = 31;
  localparam int EVENT_TYPE_LSB   = 8;
  localparam int EVENT_IDX_LSB    = 0;
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Bit positions of a button's pending-flag vector
  localparam int PEND_PRESS   = 0;
  localparam int PEND_LONG    = 1;
  localparam int PEND_RELEASE = 2;

  typedef enum logic [1:0] {
    BTN_RELEASED = 2'd0,
    BTN_PRESSED  = 2'd1,
    BTN_HELD     = 2'd2
  } btn_state_e;

  // One-hot mask of the pending flag served first: PRESS > LONG > RELEASE
  function automatic logic [2:0] pend_grant(input logic [2:0] pend);
    logic [2:0] g;
    g = 3'b000;
    if (pend[PEND_PRESS]) begin
      g = 3'b001;
    end else if (pend[PEND_LONG]) begin
      g = 3'b010;
    end else if (pend[PEND_RELEASE]) begin
      g = 3'b100;
    end else begin
      g = 3'b000;
    end
    return g;
  endfunction

  // Event type code matching pend_grant()
  function automatic logic [1:0] pend_to_type(input logic [2:0] pend);
    logic [1:0] t;
    t = 2'b00;
    if (pend[PEND_PRESS]) begin
      t = EV_PRESS;
    end else if (pend[PEND_LONG]) begin
      t = EV_LONG;
    end else if (pend[PEND_RELEASE]) begin
      t = EV_RELEASE;
    end else begin
      t = 2'b00;
    end
    return t;
  endfunction

endpackage

// File: rtl/button_debounce_fsm.sv
// ---------------------------------------------------------------------------
// button_debounce_fsm
// One push-button: 2-flop synchronizer, debounce counter, press/hold FSM and
// the three pending event flags (PRESS, LONG, RELEASE).
// Ports:
//   clk, reset  system clock, async active-high reset
//   btn_n_i     raw button, active-low, asynchronous
//   clr_i       one-hot clear of pending flags (granted by the arbiter)
//   level_o     debounced level, 1 = pressed
//   pend_o      pending flags [0]=PRESS [1]=LONG [2]=RELEASE
// ---------------------------------------------------------------------------
module button_debounce_fsm
  import qsys_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n_i,
  input  logic [2:0] clr_i,
  output logic       level_o,
  output logic [2:0] pend_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  logic              sync1_q, sync2_q;
  logic              level_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic              flip_s;
  btn_state_e        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [2:0]        pend_q;

  // Two-flop synchronizer, stored in pressed polarity (1 = pressed)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounced level flips on the cycle the counter would reach DEBOUNCE_CYCLES
  always_comb begin
    flip_s = 1'b0;
    if ((sync2_q != level_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1))) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
  end

  // Debounce counter and debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q  <= 1'b0;
      db_cnt_q <= {DB_W{1'b0}};
    end else if (sync2_q == level_q) begin
      db_cnt_q <= {DB_W{1'b0}};
    end else if (flip_s) begin
      level_q  <= ~level_q;
      db_cnt_q <= {DB_W{1'b0}};
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  // Press FSM, hold counter and pending flags; a new event flag set
  // overrides the arbiter clear for that bit in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BTN_RELEASED;
      hold_q  <= {HOLD_W{1'b0}};
      pend_q  <= 3'b000;
    end else begin
      pend_q <= pend_q & ~clr_i;
      case (state_q)
        BTN_RELEASED: begin
          hold_q <= {HOLD_W{1'b0}};
          if (flip_s && !level_q) begin
            state_q            <= BTN_PRESSED;
            pend_q[PEND_PRESS] <= 1'b1;
          end else begin
            state_q <= BTN_RELEASED;
          end
        end
        BTN_PRESSED: begin
          if (flip_s && level_q) begin
            state_q              <= BTN_RELEASED;
            hold_q               <= {HOLD_W{1'b0}};
            pend_q[PEND_RELEASE] <= 1'b1;
          end else if (hold_q == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
            state_q           <= BTN_HELD;
            hold_q            <= {HOLD_W{1'b0}};
            pend_q[PEND_LONG] <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        BTN_HELD: begin
          hold_q <= {HOLD_W{1'b0}};
          if (flip_s && level_q) begin
            state_q              <= BTN_RELEASED;
            pend_q[PEND_RELEASE] <= 1'b1;
          end else begin
            state_q <= BTN_HELD;
          end
        end
        default: begin
          state_q <= BTN_RELEASED;
          hold_q  <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/qsys_button_event_ctrl.sv
// ---------------------------------------------------------------------------
// qsys_button_event_ctrl
// Avalon-MM slave that debounces the board buttons, queues PRESS / LONG /
// RELEASE events in a FIFO and raises a level interrupt while it is non-empty.
// Ports:
//   clk, reset          system clock, async active-high reset
//   in_port             raw buttons, active-low
//   address, chipselect, read_n, write_n, writedata   Avalon-MM slave inputs
//   readdata            registered read data (latency 1)
//   irq                 irq_mask & (count != 0)
// ---------------------------------------------------------------------------
module qsys_button_event_ctrl
  import qsys_button_pkg::*;
#(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] in_port,
  input  logic [1:0]             address,
  input  logic                   chipselect,
  input  logic                   read_n,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic                   irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_BUTTONS-1:0]      level_s;
  logic [NUM_BUTTONS-1:0][2:0] pend_s;
  logic [NUM_BUTTONS-1:0][2:0] clr_s;

  logic       push_s;
  logic [2:0] gnt_idx_s;
  logic [1:0] gnt_type_s;

  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          irq_mask_q;
  logic [31:0]   rdata_q, rdata_d;

  logic rd_s, wr_s, empty_s, full_s, pop_s, flush_s, clr_ovf_s, do_push_s, drop_s;
  logic [4:0] head_s;
  logic unused_wdata_s;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debounce_fsm #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
    ) u_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_n_i (in_port[g]),
      .clr_i   (clr_s[g]),
      .level_o (level_s[g]),
      .pend_o  (pend_s[g])
    );
  end

  // Arbiter: lowest-index button with any pending flag wins; its served flag clears
  always_comb begin
    push_s     = 1'b0;
    gnt_idx_s  = 3'd0;
    gnt_type_s = 2'b00;
    clr_s      = '{default: 3'b000};
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!push_s && (pend_s[i] != 3'b000)) begin
        push_s     = 1'b1;
        gnt_idx_s  = 3'(i);
        gnt_type_s = pend_to_type(pend_s[i]);
        clr_s[i]   = pend_grant(pend_s[i]);
      end else begin
        push_s = push_s;
      end
    end
  end

  assign rd_s      = chipselect & ~read_n;
  assign wr_s      = chipselect & ~write_n;
  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == CW'(FIFO_DEPTH));
  assign pop_s     = rd_s & (address == REG_EVENT) & ~empty_s;
  assign flush_s   = wr_s & (address == REG_CONTROL) & writedata[CTRL_FLUSH_BIT];
  assign clr_ovf_s = wr_s & (address == REG_CONTROL) & writedata[CTRL_CLR_OVF_BIT];
  // A pop frees a slot in the same cycle, so push still lands when full
  assign do_push_s = push_s & (~full_s | pop_s) & ~flush_s;
  // A flushed push is lost silently, not counted as overflow
  assign drop_s    = push_s & full_s & ~pop_s & ~flush_s;
  assign head_s    = mem_q[rd_ptr_q];
  assign unused_wdata_s = &{1'b0, writedata[31:2]};

  // Event FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 5'b00000;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush_s) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= {gnt_idx_s, gnt_type_s};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag and interrupt mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q      <= 1'b0;
      irq_mask_q <= 1'b0;
    end else begin
      if (drop_s) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf_s) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q;
      end
      if (wr_s && (address == REG_IRQMASK)) begin
        irq_mask_q <= writedata[0];
      end else begin
        irq_mask_q <= irq_mask_q;
      end
    end
  end

  // Read mux; EVENT shows the head being popped this cycle
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (rd_s) begin
      case (address)
        REG_STATUS: begin
          rdata_d[STATUS_COUNT_LSB +: 7]           = 7'(count_q);
          rdata_d[STATUS_OVF_BIT]                  = ovf_q;
          rdata_d[STATUS_LEVEL_LSB +: NUM_BUTTONS] = level_s;
        end
        REG_EVENT: begin
          if (!empty_s) begin
            rdata_d[EVENT_VALID_BIT]       = 1'b1;
            rdata_d[EVENT_TYPE_LSB +: 2]   = head_s[1:0];
            rdata_d[EVENT_IDX_LSB +: 3]    = head_s[4:2];
          end else begin
            rdata_d = 32'h0000_0000;
          end
        end
        REG_IRQMASK: rdata_d[0] = irq_mask_q;
        REG_CONTROL: rdata_d    = 32'h0000_0000;
        default:     rdata_d    = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_mask_q & ~empty_s;

endmodule
